// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the shared memory arbiter and IF_ID.
// Owns the fetch PC, keeps at most one fetch in flight and buffers {inst, pc} pairs.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0033
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   input  logic                   halt,
   output logic                   mem_req,
   output logic [31:0]            mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [31:0]            mem_rdata,
   output logic                   inst_valid,
   output logic [31:0]            inst,
   output logic [31:0]            inst_pc,
   output logic [31:0]            inst_pc4,
   input  logic                   inst_ready,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [1:0]             state_dbg
);

   // Handshakes: a fetch is accepted on mem_req & mem_gnt and returns exactly one mem_rvalid
   // later, in order; an instruction leaves the queue on inst_valid & inst_ready.
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0]   count;
   logic [AW:0]   committed;
   logic          outstanding;
   logic          grant;
   logic          push;
   logic          pop;
   logic          redirect_lsb_unused;

   assign redirect_lsb_unused = ^redirect_pc[1:0];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   // Next state; a redirect overrides everything, parking in DRAIN only if a stale
   // response is still to come.
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:   if (grant) state_nxt = S_WAIT;
         S_WAIT:  if (mem_rvalid) state_nxt = grant ? S_WAIT : S_RUN;
         S_DRAIN: if (mem_rvalid) state_nxt = S_RUN;
         default: state_nxt = S_RUN;
      endcase
      if (redirect_valid) begin
         if (state != S_RUN && !mem_rvalid) state_nxt = S_DRAIN;
         else                               state_nxt = S_RUN;
      end
   end

   // FSM outputs: request issue under the credit rule, FIFO push/pop strobes.
   always_comb begin
      outstanding = (state != S_RUN);
      committed   = count + {{AW{1'b0}}, outstanding};
      mem_req     = !rst && !halt && !redirect_valid && (committed < FULL) &&
                    (state == S_RUN || (state == S_WAIT && mem_rvalid));
      grant       = mem_req && mem_gnt;
      push        = (state == S_WAIT) && mem_rvalid && !redirect_valid;
      pop         = inst_valid && inst_ready && !redirect_valid;
   end

   assign mem_addr  = fetch_pc;
   assign state_dbg = state;
   assign occupancy = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
         end else if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
         end
         if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + (AW+1)'(1);
               2'b01:   count <= count - (AW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[tail] <= mem_rdata;
         pc_mem[tail]   <= req_pc;
      end
   end

   always_comb begin
      inst_valid = (count != '0);
      inst       = NOP;
      inst_pc    = '0;
      inst_pc4   = '0;
      if (inst_valid) begin
         inst     = inst_mem[head];
         inst_pc  = pc_mem[head];
         inst_pc4 = pc_mem[head] + 32'd4;
      end
   end

   // The credit rule makes overflow unreachable.
   assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory responder, a scoreboard of {pc, inst} pairs and
// one task per scenario.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0033;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;
   logic        inst_ready;
   logic [2:0]  occupancy;
   logic [1:0]  state_dbg;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } pend_t;

   pend_t       pend_q[$];
   logic [63:0] exp_q[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          n_gnt = 0;
   int          n_pop = 0;
   int          rv_delay = 1;
   bit          rv_rand = 0;
   bit          gnt_on = 1;
   bit          gnt_rand = 0;
   bit          ready_rand = 0;
   logic [31:0] rsp_addr = '0;
   int          rsp_epoch = -1;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_pc4       (inst_pc4),
      .inst_ready     (inst_ready),
      .occupancy      (occupancy),
      .state_dbg      (state_dbg)
   );

   // Clock and reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[17:2]};
   endfunction

   // One clock: scoreboard sampling at negedge, memory responder drive after posedge.
   task automatic cycle();
      pend_t       p;
      logic [63:0] e;
      @(negedge clk);
      if (!rst) begin
         if (inst_valid && inst_ready) begin
            n_pop++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_extra: got pc=%h inst=%h, required no entry", inst_pc, inst);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e[63:32] || inst !== e[31:0] || inst_pc4 !== e[63:32] + 32'd4) begin
                  n_err++;
                  $display("FAIL sb_entry: got pc=%h inst=%h pc4=%h, required pc=%h inst=%h pc4=%h",
                           inst_pc, inst, inst_pc4, e[63:32], e[31:0], e[63:32] + 32'd4);
               end
            end
         end
         if (mem_rvalid && rsp_epoch == epoch && !redirect_valid)
            exp_q.push_back({rsp_addr, mem_word(rsp_addr)});
         if (mem_req && mem_gnt) begin
            n_gnt++;
            p.addr  = mem_addr;
            p.due   = cyc + (rv_rand ? int'($urandom_range(1, 3)) : rv_delay);
            p.epoch = epoch;
            pend_q.push_back(p);
         end
         if (redirect_valid) begin
            exp_q.delete();
            epoch++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         p          = pend_q.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = mem_word(p.addr);
         rsp_addr   = p.addr;
         rsp_epoch  = p.epoch;
      end
      mem_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : gnt_on;
      if (ready_rand) inst_ready = ($urandom_range(0, 3) != 0);
      #1;
   endtask

   task automatic do_reset();
      gnt_on = 1; gnt_rand = 0; rv_rand = 0; rv_delay = 1; ready_rand = 0;
      inst_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; mem_gnt = 1'b1;
      rst = 1'b1;
      cycle();
      cycle();
      pend_q.delete();
      exp_q.delete();
      mem_rvalid = 1'b0;
      epoch++;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      gnt_on = 1; mem_gnt = 1'b1; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
      rst = 1'b1;
      cycle();
      cycle();
      n_cmp++;
      if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || inst_pc4 !== 32'h0) begin
         n_err++;
         $display("FAIL rst_outputs: got v=%b inst=%h pc=%h pc4=%h, required 0/%h/0/0",
                  inst_valid, inst, inst_pc, inst_pc4, NOP);
      end
      n_cmp++;
      if (occupancy !== 3'd0 || mem_req !== 1'b0 || state_dbg !== 2'd0) begin
         n_err++;
         $display("FAIL rst_state: got occ=%0d req=%b st=%0d, required 0/0/0", occupancy, mem_req, state_dbg);
      end
      pend_q.delete();
      exp_q.delete();
      mem_rvalid = 1'b0;
      epoch++;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         n_err++;
         $display("FAIL rst_first_req: got req=%b addr=%h, required 1/00000000", mem_req, mem_addr);
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         n_cmp++;
         if (inst_valid !== (i >= 3)) begin
            n_err++;
            $display("FAIL stream_valid: cycle %0d got %b, required %b", i, inst_valid, (i >= 3));
         end
         if (i >= 3) begin
            n_cmp++;
            if (inst_pc !== 32'(4 * (i - 3))) begin
               n_err++;
               $display("FAIL stream_pc: cycle %0d got %h, required %h", i, inst_pc, 32'(4 * (i - 3)));
            end
         end
         cycle();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      inst_ready = 1'b0;
      n_gnt = 0;
      for (int i = 0; i < 12; i++) cycle();
      n_cmp++;
      if (n_gnt != DEPTH) begin
         n_err++;
         $display("FAIL bp_grants: got %0d, required %0d", n_gnt, DEPTH);
      end
      n_cmp++;
      if (occupancy !== 3'd4 || mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL bp_full: got occ=%0d req=%b, required 4/0", occupancy, mem_req);
      end
      inst_ready = 1'b1;
      cycle();
      inst_ready = 1'b0;
      #1;
      n_cmp++;
      if (occupancy !== 3'd3 || mem_req !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: got occ=%0d req=%b, required 3/1", occupancy, mem_req);
      end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      rv_delay = 3;
      cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL drain_req_redirect: got %b, required 0", mem_req);
      end
      cycle();
      redirect_valid = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h100 || state_dbg !== 2'd2) begin
         n_err++;
         $display("FAIL drain_state: got req=%b addr=%h st=%0d, required 0/00000100/2", mem_req, mem_addr, state_dbg);
      end
      cycle();
      cycle();
      n_cmp++;
      if (occupancy !== 3'd0 || inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL drain_after: got occ=%0d v=%b req=%b addr=%h, required 0/0/1/00000100",
                  occupancy, inst_valid, mem_req, mem_addr);
      end
      for (int i = 0; i < 20 && !inst_valid; i++) cycle();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
         n_err++;
         $display("FAIL drain_first: got v=%b pc=%h inst=%h, required 1/00000100/%h",
                  inst_valid, inst_pc, inst, mem_word(32'h100));
      end
      for (int i = 0; i < 6; i++) cycle();
   endtask

   task automatic test_wrap();
      do_reset();
      gnt_on = 1'b0;
      mem_gnt = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0203;
      cycle();
      redirect_valid = 1'b0;
      #1;
      n_cmp++;
      if (mem_addr !== 32'h200 || mem_req !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_align: got addr=%h req=%b, required 00000200/1", mem_addr, mem_req);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      gnt_on = 1'b1;
      mem_gnt = 1'b1;
      #1;
      n_cmp++;
      if (mem_addr !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL wrap_top: got %h, required fffffffc", mem_addr);
      end
      cycle();
      n_cmp++;
      if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_next: got addr=%h req=%b, required 00000000/1", mem_addr, mem_req);
      end
      for (int i = 0; i < 10 && !inst_valid; i++) cycle();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_pc4 !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_pc4: got v=%b pc=%h pc4=%h, required 1/fffffffc/00000000", inst_valid, inst_pc, inst_pc4);
      end
      cycle();
      n_cmp++;
      if (inst_pc !== 32'h0 || inst_pc4 !== 32'h4) begin
         n_err++;
         $display("FAIL wrap_after: got pc=%h pc4=%h, required 00000000/00000004", inst_pc, inst_pc4);
      end
      for (int i = 0; i < 4; i++) cycle();
   endtask

   task automatic test_halt();
      int pops0;
      int bad_req;
      do_reset();
      inst_ready = 1'b0;
      cycle();
      cycle();
      cycle();
      halt = 1'b1;
      #1;
      n_cmp++;
      if (occupancy !== 3'd2 || state_dbg !== 2'd1 || mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL halt_entry: got occ=%0d st=%0d req=%b, required 2/1/0", occupancy, state_dbg, mem_req);
      end
      inst_ready = 1'b1;
      pops0 = n_pop;
      bad_req = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (mem_req !== 1'b0) bad_req++;
      end
      n_cmp++;
      if (n_pop - pops0 != 3) begin
         n_err++;
         $display("FAIL halt_delivered: got %0d, required 3", n_pop - pops0);
      end
      n_cmp++;
      if (bad_req != 0) begin
         n_err++;
         $display("FAIL halt_no_req: got %0d request cycles, required 0", bad_req);
      end
      n_cmp++;
      if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || occupancy !== 3'd0) begin
         n_err++;
         $display("FAIL halt_empty: got v=%b inst=%h pc=%h occ=%0d, required 0/%h/0/0",
                  inst_valid, inst, inst_pc, occupancy, NOP);
      end
      halt = 1'b0;
   endtask

   task automatic test_redirect_pop_push();
      do_reset();
      for (int i = 0; i < 4; i++) cycle();
      n_cmp++;
      if (inst_valid !== 1'b1 || occupancy !== 3'd1) begin
         n_err++;
         $display("FAIL rpp_pre: got v=%b occ=%0d, required 1/1", inst_valid, occupancy);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      cycle();
      redirect_valid = 1'b0;
      #1;
      n_cmp++;
      if (occupancy !== 3'd0 || inst_valid !== 1'b0 || state_dbg !== 2'd0) begin
         n_err++;
         $display("FAIL rpp_flush: got occ=%0d v=%b st=%0d, required 0/0/0", occupancy, inst_valid, state_dbg);
      end
      cycle();
      cycle();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
         n_err++;
         $display("FAIL rpp_latency: got v=%b pc=%h, required 1/00000040", inst_valid, inst_pc);
      end
      for (int i = 0; i < 5; i++) cycle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      gnt_rand = 1;
      rv_rand = 1;
      ready_rand = 1;
      for (int i = 0; i < 400; i++) begin
         cycle();
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom();
         halt = ($urandom_range(0, 9) == 0);
      end
      redirect_valid = 1'b0;
      halt = 1'b1;
      gnt_rand = 0;
      ready_rand = 0;
      inst_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (pend_q.size() == 0 && !inst_valid && !mem_rvalid) break;
      end
      n_cmp++;
      if (exp_q.size() != 0 || occupancy !== 3'd0) begin
         n_err++;
         $display("FAIL b2b_drain: got %0d expected entries left, occ=%0d, required 0/0", exp_q.size(), occupancy);
      end
      halt = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      halt = 1'b0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      inst_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drain();
      test_wrap();
      test_halt();
      test_redirect_pop_push();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
